// File: rtl/pwm_gate_pkg.sv
// Shared types and constants for the three-phase gate dead-time stage.
//   phase_state_t : per-phase sequencing state
//   req_t         : decoded per-phase command request
//   decode_req    : maps one phase's registered high/low command bits to req_t
package pwm_gate_pkg;

   localparam int DEAD_CYCLES_DEF = 16;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_DEAD_H,
      ST_ON_H,
      ST_DEAD_L,
      ST_ON_L
   } phase_state_t;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_H,
      REQ_L,
      REQ_CONFLICT
   } req_t;

   function automatic req_t decode_req(input logic h, input logic l);
      req_t r;
      unique case ({h, l})
         2'b10:   r = REQ_H;
         2'b01:   r = REQ_L;
         2'b11:   r = REQ_CONFLICT;
         default: r = REQ_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dead_time_phase.sv
// One inverter phase: dead-time FSM, dead-time down-counter, registered gate
// drives and the sticky shoot-through error flag.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_cmd_h, i_cmd_l  : registered high/low commands for this phase
//   i_force_off       : drop both gates and return to OFF at this edge
//   i_err_clr         : clear the sticky shoot-through flag
//   o_gate_h, o_gate_l: registered gate drives
//   o_shoot_err       : sticky flag, set when both commands were high
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_OFF    | both gates off, no request pending
// ST_DEAD_H | both gates off, counting dead time before high side
// ST_ON_H   | high-side gate on
// ST_DEAD_L | both gates off, counting dead time before low side
// ST_ON_L   | low-side gate on
module dead_time_phase
   import pwm_gate_pkg::*;
#(
   parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_cmd_h,
   input  logic i_cmd_l,
   input  logic i_force_off,
   input  logic i_err_clr,
   output logic o_gate_h,
   output logic o_gate_l,
   output logic o_shoot_err
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYCLES - 1);

   phase_state_t     r_state;
   phase_state_t     w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_gate_h;
   logic             r_gate_l;
   logic             r_shoot_err;
   logic             w_gate_h_nxt;
   logic             w_gate_l_nxt;
   req_t             w_req;

   assign w_req = decode_req(i_cmd_h, i_cmd_l);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_OFF;
         r_cnt    <= '0;
         r_gate_h <= 1'b0;
         r_gate_l <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gate_h <= w_gate_h_nxt;
         r_gate_l <= w_gate_l_nxt;
      end
   end

   // A conflict behaves like NONE in the FSM, so it falls into the default arms.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (i_force_off) begin
         w_state_nxt = ST_OFF;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            ST_OFF: begin
               if (w_req == REQ_H) begin
                  w_state_nxt = ST_DEAD_H;
                  w_cnt_nxt   = RELOAD;
               end else if (w_req == REQ_L) begin
                  w_state_nxt = ST_DEAD_L;
                  w_cnt_nxt   = RELOAD;
               end
            end
            ST_DEAD_H: begin
               if (w_req == REQ_H) begin
                  if (r_cnt == '0) w_state_nxt = ST_ON_H;
                  else             w_cnt_nxt   = r_cnt - 1'b1;
               end else if (w_req == REQ_L) begin
                  w_state_nxt = ST_DEAD_L;
                  w_cnt_nxt   = RELOAD;
               end else begin
                  w_state_nxt = ST_OFF;
               end
            end
            ST_ON_H: begin
               if (w_req == REQ_L) begin
                  w_state_nxt = ST_DEAD_L;
                  w_cnt_nxt   = RELOAD;
               end else if (w_req != REQ_H) begin
                  w_state_nxt = ST_OFF;
               end
            end
            ST_DEAD_L: begin
               if (w_req == REQ_L) begin
                  if (r_cnt == '0) w_state_nxt = ST_ON_L;
                  else             w_cnt_nxt   = r_cnt - 1'b1;
               end else if (w_req == REQ_H) begin
                  w_state_nxt = ST_DEAD_H;
                  w_cnt_nxt   = RELOAD;
               end else begin
                  w_state_nxt = ST_OFF;
               end
            end
            ST_ON_L: begin
               if (w_req == REQ_H) begin
                  w_state_nxt = ST_DEAD_H;
                  w_cnt_nxt   = RELOAD;
               end else if (w_req != REQ_L) begin
                  w_state_nxt = ST_OFF;
               end
            end
            default: begin
               w_state_nxt = ST_OFF;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Gate flops follow the state being entered, so they switch on the same
   // edge as the state without any combinational decode at the pins.
   always_comb begin
      w_gate_h_nxt = (w_state_nxt == ST_ON_H);
      w_gate_l_nxt = (w_state_nxt == ST_ON_L);
   end

   // Set wins over clear so a conflict coinciding with a clear is not lost.
   always_ff @(posedge clk) begin
      if (rst)                        r_shoot_err <= 1'b0;
      else if (w_req == REQ_CONFLICT) r_shoot_err <= 1'b1;
      else if (i_err_clr)             r_shoot_err <= 1'b0;
   end

   assign o_gate_h    = r_gate_h;
   assign o_gate_l    = r_gate_l;
   assign o_shoot_err = r_shoot_err;

endmodule

// File: rtl/gate_deadtime.sv
// Three-phase dead-time insertion and gate protection (U=bit0, V=bit1, W=bit2).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   en                   : gate enable, low forces all gates off
//   fault_in             : external fault, forces gates off and sets the latch
//   fault_clr            : clears the fault latch and shoot-through flags
//   cmd_h, cmd_l         : raw per-phase high/low commands
//   gate_h, gate_l       : registered gate drives
//   shoot_err            : sticky per-phase shoot-through flags
//   fault_latched        : sticky fault status
module gate_deadtime
   import pwm_gate_pkg::*;
#(
   parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       fault_in,
   input  logic       fault_clr,
   input  logic [2:0] cmd_h,
   input  logic [2:0] cmd_l,
   output logic [2:0] gate_h,
   output logic [2:0] gate_l,
   output logic [2:0] shoot_err,
   output logic       fault_latched
);

   logic [2:0] r_cmd_h;
   logic [2:0] r_cmd_l;
   logic       r_fault_latched;
   logic       w_force_off;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd_h <= '0;
         r_cmd_l <= '0;
      end else begin
         r_cmd_h <= cmd_h;
         r_cmd_l <= cmd_l;
      end
   end

   // fault_in has priority over fault_clr on the same edge.
   always_ff @(posedge clk) begin
      if (rst)            r_fault_latched <= 1'b0;
      else if (fault_in)  r_fault_latched <= 1'b1;
      else if (fault_clr) r_fault_latched <= 1'b0;
   end

   // fault_in is used unregistered so the gates drop on the very edge it is seen.
   assign w_force_off = ~en | r_fault_latched | fault_in;

   for (genvar g = 0; g < 3; g++) begin : g_phase
      dead_time_phase #(
         .DEAD_CYCLES (DEAD_CYCLES),
         .CNT_W       (CNT_W)
      ) u_phase (
         .clk         (clk),
         .rst         (rst),
         .i_cmd_h     (r_cmd_h[g]),
         .i_cmd_l     (r_cmd_l[g]),
         .i_force_off (w_force_off),
         .i_err_clr   (fault_clr),
         .o_gate_h    (gate_h[g]),
         .o_gate_l    (gate_l[g]),
         .o_shoot_err (shoot_err[g])
      );
   end

   assign fault_latched = r_fault_latched;

endmodule

// File: tb/tb_gate_deadtime.sv
module tb_gate_deadtime;

   localparam int DT = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic       fault_in;
   logic       fault_clr;
   logic [2:0] cmd_h;
   logic [2:0] cmd_l;
   logic [2:0] gate_h;
   logic [2:0] gate_l;
   logic [2:0] shoot_err;
   logic       fault_latched;

   int n_pass  = 0;
   int n_total = 0;

   gate_deadtime #(
      .DEAD_CYCLES (DT),
      .CNT_W       (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .fault_in      (fault_in),
      .fault_clr     (fault_clr),
      .cmd_h         (cmd_h),
      .cmd_l         (cmd_l),
      .gate_h        (gate_h),
      .gate_l        (gate_l),
      .shoot_err     (shoot_err),
      .fault_latched (fault_latched)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] h;
      logic [2:0] l;
      logic       en;
      logic       fin;
      logic       fclr;
      int         hold;
      logic [2:0] exp_h;
      logic [2:0] exp_l;
      logic [2:0] exp_err;
      logic       exp_flt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic [2:0] h, logic [2:0] l, logic e,
                               logic fin, logic fclr, int hold, logic [2:0] eh,
                               logic [2:0] el, logic [2:0] ee, logic ef);
      vec_t v;
      v.name = name; v.h = h; v.l = l; v.en = e; v.fin = fin; v.fclr = fclr;
      v.hold = hold; v.exp_h = eh; v.exp_l = el; v.exp_err = ee; v.exp_flt = ef;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Sample point: 1 time unit after the rising edge; inputs change here too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] h, input logic [2:0] l, input logic e,
                        input logic fin, input logic fclr);
      cmd_h = h; cmd_l = l; en = e; fault_in = fin; fault_clr = fclr;
   endtask

   initial begin
      int n;
      int hi_cnt;
      int hold_left;
      int off_cnt[3];
      logic [2:0] prev_h, prev_l;
      int overlap_err, dead_err;

      rst = 1'b1;
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
      #2;
      // ---- reset with random commands ----
      tick();
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
      tick();
      chk("reset_gate_h", {29'd0, gate_h}, 32'd0);
      chk("reset_gate_l", {29'd0, gate_l}, 32'd0);
      chk("reset_shoot_err", {29'd0, shoot_err}, 32'd0);
      chk("reset_fault_latched", {31'd0, fault_latched}, 32'd0);

      // ---- turn-on latency: 6 edges with DT=4 ----
      rst = 1'b0;
      drive(3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
      repeat (5) tick();
      chk("turn_on_edge5_low", {29'd0, gate_h}, 32'd0);
      tick();
      chk("turn_on_edge6_high", {29'd0, gate_h}, 32'd1);

      // ---- table-driven vectors ----
      vecs.push_back(mk("hold_u_h",      3'b001, 3'b000, 1, 0, 0, 8, 3'b001, 3'b000, 3'b000, 0));
      vecs.push_back(mk("mix_phases",    3'b010, 3'b101, 1, 0, 0, 8, 3'b010, 3'b101, 3'b000, 0));
      vecs.push_back(mk("all_none",      3'b000, 3'b000, 1, 0, 0, 3, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("disabled",      3'b111, 3'b000, 0, 0, 0, 8, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("enable_dead",   3'b111, 3'b000, 1, 0, 0, 2, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("enable_on",     3'b111, 3'b000, 1, 0, 0, 5, 3'b111, 3'b000, 3'b000, 0));
      vecs.push_back(mk("all_low",       3'b000, 3'b111, 1, 0, 0, 8, 3'b000, 3'b111, 3'b000, 0));
      vecs.push_back(mk("fault_pulse",   3'b000, 3'b111, 1, 1, 0, 1, 3'b000, 3'b000, 3'b000, 1));
      vecs.push_back(mk("fault_held",    3'b000, 3'b111, 1, 0, 0, 8, 3'b000, 3'b000, 3'b000, 1));
      vecs.push_back(mk("clr_vs_fault",  3'b000, 3'b111, 1, 1, 1, 1, 3'b000, 3'b000, 3'b000, 1));
      vecs.push_back(mk("clean_clear",   3'b000, 3'b111, 1, 0, 1, 1, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("post_clr_dead", 3'b000, 3'b111, 1, 0, 0, 4, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("post_clr_on",   3'b000, 3'b111, 1, 0, 0, 1, 3'b000, 3'b111, 3'b000, 0));
      vecs.push_back(mk("conflict_w",    3'b100, 3'b111, 1, 0, 0, 3, 3'b000, 3'b011, 3'b100, 0));
      vecs.push_back(mk("err_sticky",    3'b000, 3'b011, 1, 0, 0, 3, 3'b000, 3'b011, 3'b100, 0));
      vecs.push_back(mk("err_clear",     3'b000, 3'b011, 1, 0, 1, 1, 3'b000, 3'b011, 3'b000, 0));
      vecs.push_back(mk("conflict_clr",  3'b001, 3'b011, 1, 0, 1, 3, 3'b000, 3'b010, 3'b001, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].h, vecs[i].l, vecs[i].en, vecs[i].fin, vecs[i].fclr);
         repeat (vecs[i].hold) tick();
         chk({vecs[i].name, "_gate_h"}, {29'd0, gate_h}, {29'd0, vecs[i].exp_h});
         chk({vecs[i].name, "_gate_l"}, {29'd0, gate_l}, {29'd0, vecs[i].exp_l});
         chk({vecs[i].name, "_shoot_err"}, {29'd0, shoot_err}, {29'd0, vecs[i].exp_err});
         chk({vecs[i].name, "_fault"}, {31'd0, fault_latched}, {31'd0, vecs[i].exp_flt});
      end

      // ---- H to L swap on U ----
      drive(3'b001, 3'b000, 1'b1, 1'b0, 1'b1);
      repeat (8) tick();
      fault_clr = 1'b0;
      chk("swap_pre_on", {29'd0, gate_h}, 32'd1);
      drive(3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
      tick();
      chk("swap_edge1_still_h", {31'd0, gate_h[0]}, 32'd1);
      tick();
      chk("swap_edge2_h_off", {31'd0, gate_h[0]}, 32'd0);
      n = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (gate_l[0]) break;
         n++;
      end
      chk("swap_l_on", {31'd0, gate_l[0]}, 32'd1);
      chk("swap_both_off_cycles", n, DT);

      // ---- short pulses on V ----
      drive(3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      repeat (4) tick();
      drive(3'b010, 3'b000, 1'b1, 1'b0, 1'b0);
      hi_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 2) cmd_h = 3'b000;
         if (gate_h[1]) hi_cnt++;
      end
      chk("pulse3_high_cycles", hi_cnt, 0);
      drive(3'b010, 3'b000, 1'b1, 1'b0, 1'b0);
      hi_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 4) cmd_h = 3'b000;
         if (gate_h[1]) hi_cnt++;
      end
      chk("pulse5_high_cycles", hi_cnt, 1);

      // ---- random invariant stream ----
      overlap_err = 0;
      dead_err    = 0;
      hold_left   = 0;
      prev_h      = gate_h;
      prev_l      = gate_l;
      for (int i = 0; i < 3; i++) off_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         if (hold_left == 0) begin
            cmd_h = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) cmd_l = 3'($urandom_range(0, 7));
            else                            cmd_l = 3'($urandom_range(0, 7)) & ~cmd_h;
            hold_left = $urandom_range(1, 12);
         end
         hold_left--;
         en        = ($urandom_range(0, 99) < 97);
         fault_in  = ($urandom_range(0, 199) == 0);
         fault_clr = ($urandom_range(0, 19) == 0);
         tick();
         if ((gate_h & gate_l) != 3'b000) overlap_err++;
         for (int i = 0; i < 3; i++) begin
            if ((gate_h[i] && !prev_h[i]) || (gate_l[i] && !prev_l[i])) begin
               if (off_cnt[i] < DT) dead_err++;
            end
            if (gate_h[i] || gate_l[i]) off_cnt[i] = 0;
            else                        off_cnt[i]++;
         end
         prev_h = gate_h;
         prev_l = gate_l;
      end
      chk("rand_overlap_events", overlap_err, 0);
      chk("rand_short_dead_events", dead_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gate_deadtime.md
# gate_deadtime

Three-phase dead-time insertion and gate-protection stage between the sine-PWM generators and the inverter gate pins. It takes raw high/low-side commands per phase (U, V, W) and produces gate drives with the following guarantees:
- On each phase, the high and low sides are never on together.
- Every turn-on is preceded by at least `DEAD_CYCLES` cycles with both sides off.
- All gates drop on fault or disable.

Commands and gate outputs are in the same `clk` domain.

## Interface
Parameters:
- `DEAD_CYCLES`, default 16: dead time in `clk` cycles; legal range 1 to 2^`CNT_W`.
- `CNT_W`, default 8: dead-time counter width.

Ports:
- `clk`, in, 1: single system clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: gate enable; low forces all gates off.
- `fault_in`, in, 1: external fault, e.g. overcurrent; sampled each edge.
- `fault_clr`, in, 1: clears the latched fault and the sticky error flags.
- `cmd_h`, in, 3: high-side commands; bit0 = U, bit1 = V, bit2 = W.
- `cmd_l`, in, 3: low-side commands, same bit order.
- `gate_h`, out, 3: registered high-side gate drives.
- `gate_l`, out, 3: registered low-side gate drives.
- `shoot_err`, out, 3: sticky per phase; set when `cmd_h[i]` and `cmd_l[i]` are both high.
- `fault_latched`, out, 1: sticky fault status.

## Operation
- **Input register:** `cmd_h` and `cmd_l` are registered once (`cmd_r`).
- **Request decode per phase**, from `cmd_r`:
  - H = h & !l
  - L = l & !h
  - NONE = !h & !l
  - CONFLICT = h & l; treated as NONE and also sets `shoot_err[i]`.
- **Per-phase FSM states:** OFF, DEAD_H, ON_H, DEAD_L, ON_L.
- **Gate outputs:** `gate_h[i]` is a dedicated flop that is 1 only in ON_H; `gate_l[i]` likewise for ON_L. Outputs are never decoded combinationally from the state.
- **FSM transitions:**
  - OFF:
    - H → DEAD_H, load cnt = `DEAD_CYCLES`−1.
    - L → DEAD_L, load cnt = `DEAD_CYCLES`−1.
    - otherwise stay.
  - DEAD_H:
    - H with cnt == 0 → ON_H.
    - H with cnt != 0 → cnt−1.
    - L → DEAD_L with counter reload (full dead time restarts).
    - NONE → OFF.
  - ON_H:
    - H → stay.
    - L → DEAD_L with reload.
    - NONE → OFF.
  - DEAD_L and ON_L: symmetric to DEAD_H and ON_H.
- **Force-off condition:** (`en` == 0) | `fault_latched` | `fault_in`. While it holds, every phase goes to OFF with both gates 0 at that edge. When it releases, phases leave OFF normally, so the full dead time applies.
- **Fault latch:**
  - `fault_latched` is set on any edge with `fault_in` = 1.
  - It is cleared on an edge with `fault_clr` = 1 and `fault_in` = 0.
  - `fault_in` wins if both are asserted on the same edge.
- **Error flags:** `shoot_err[i]` is cleared by `fault_clr` or `rst`. A set event wins over a simultaneous `fault_clr`.
- **Reset:** `rst` drives all states to OFF, cnt = 0, `cmd_r` = 0, and every output to 0.
- **Safety invariant:** `gate_h[i]` & `gate_l[i]` is never 1, under any input sequence.

## Timing
- **Turn-off latency:** the command falls before edge k; the gate is low after edge k+1, i.e. 2 edges.
- **Turn-on latency:** a valid request is present before edge k; the phase enters DEAD at edge k+1; the gate goes high after edge k+1+`DEAD_CYCLES`.
- **Minimum both-off interval** between one side off and the other side on: `DEAD_CYCLES` full cycles.
- **Fault response:** `fault_in` high before edge k; gates are 0 after edge k (1 edge, unregistered path into the next-state logic).
- **Short pulses:** a command pulse shorter than `DEAD_CYCLES`+1 cycles never reaches the gate.

## Structure
- **Package `pwm_gate_pkg`** holds:
  - `phase_state_t`, the enum for OFF/DEAD_H/ON_H/DEAD_L/ON_L;
  - `req_t`, the enum for H/L/NONE/CONFLICT;
  - the default dead-time constant.
- **Sub-module `dead_time_phase`** contains one FSM, the counter, the two gate flops and the `shoot_err` flop. It is instantiated three times.
- **Top level** holds the input register, the fault latch and the force-off logic.

## Test plan
All scenarios use `DEAD_CYCLES` = 4.
- **Reset:** assert `rst` for 2 cycles with random commands → all outputs 0. Then `cmd_h[0]` = 1 → `gate_h[0]` rises exactly 6 edges after the command.
- **H to L swap:** U goes from ON_H to `cmd_l` = 1 and `cmd_h` = 0 on the same cycle → `gate_h[0]` falls after 2 edges; `gate_l[0]` rises 4 edges later; both are 0 for exactly 4 cycles.
- **Short pulse:** a 3-cycle `cmd_h[1]` pulse from OFF → `gate_h[1]` stays 0. A 5-cycle pulse → `gate_h[1]` is high for 1 cycle.
- **Conflict:** `cmd_h[2]` and `cmd_l[2]` both 1 → both W gates are 0 and `shoot_err[2]` = 1. The flag stays set after the conflict ends and is cleared by `fault_clr`.
- **Fault:**
  - `fault_in` pulses for 1 cycle during ON_L → all gates are 0 at that edge and `fault_latched` = 1.
  - `fault_clr` asserted with `fault_in` still high → the latch stays set.
  - After a clean clear → gates return only after the full dead time.
- **Invariant:** a random 10k-cycle command/`en`/`fault_in` stream → `gate_h` & `gate_l` is always 0, and every turn-on is preceded by at least 4 cycles with both gates off.
